// File: rtl/adder_pkg.sv
// Shared definitions for the serial digit adder: FSM state encoding and
// the helper that sizes the digit counter.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..n-1, never fewer than one so a single-digit
  // configuration still has a legal counter vector.
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Ripple chain of DIGIT full-adder cells. This chain is the only long
// combinational path of the serial adder, so DIGIT directly sets its depth.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] sum,
  output logic             co,
  output logic             c_msb
);

  // Walk the carry from bit 0 upwards, one full-adder cell per bit.
  always_comb begin
    logic c;
    // NOTE: every output gets a default first, so no path leaves a value unassigned and no latch is inferred.
    sum   = '0;
    c_msb = ci;
    c     = ci;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) c_msb = c;
      sum[i] = x[i] ^ y[i] ^ c;
      c      = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end

endmodule

// File: rtl/serial_digit_adder.sv
// Multi-cycle two's-complement adder/subtractor. Operands are accepted over
// a valid/ready handshake, summed DIGIT bits per clock, and the completed
// sum, carry-out and signed overflow are offered over a second handshake.
module serial_digit_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int             NDIG     = WIDTH / DIGIT;
  localparam int             CW       = clog2_min1(NDIG);
  localparam logic [CW-1:0]  LAST_DIG = CW'(NDIG - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT-1:0] dig_sum;
  logic             dig_co;
  logic             dig_cmsb;

  logic [WIDTH-1:0] a_next;
  logic [WIDTH-1:0] b_next;
  logic [WIDTH-1:0] res_next;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .x     (a_sr[DIGIT-1:0]),
    .y     (b_sr[DIGIT-1:0]),
    .ci    (carry),
    .sum   (dig_sum),
    .co    (dig_co),
    .c_msb (dig_cmsb)
  );

  // Next values of the operand and result shift registers. A single-digit
  // configuration has nothing to shift: the one digit is the whole result.
  if (NDIG == 1) begin : g_single
    assign a_next   = '0;
    assign b_next   = '0;
    assign res_next = dig_sum;
  end else begin : g_multi
    assign a_next   = {{DIGIT{1'b0}}, a_sr[WIDTH-1:DIGIT]};
    assign b_next   = {{DIGIT{1'b0}}, b_sr[WIDTH-1:DIGIT]};
    assign res_next = {dig_sum, res[WIDTH-1:DIGIT]};
  end

  // Control FSM with registered handshake flags, shift datapath and the
  // result registers that only change when a full result is complete.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift registers are reset too, so a fresh block never exposes stale operand bits.
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      res       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      s         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on pre-edge values.
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sr     <= a;
            b_sr     <= b ^ {WIDTH{sub}};
            carry    <= cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sr  <= a_next;
          b_sr  <= b_next;
          res   <= res_next;
          carry <= dig_co;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_DIG) begin
            s         <= res_next;
            cout      <= dig_co;
            ovf       <= dig_cmsb ^ dig_co;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_digit_adder.sv
// Directed-vector bench for serial_digit_adder: a 16-bit/4-bit-digit main
// instance plus two 8-bit instances (one digit of 8 bits, eight of 1 bit).
module tb_serial_digit_adder;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Main instance, WIDTH=16 DIGIT=4
  logic        in_valid, out_ready, cin, sub;
  logic [15:0] a, b;
  logic        in_ready, out_valid, cout, ovf, busy;
  logic [15:0] s;

  // 8-bit instances share their inputs
  logic       in_valid8, out_ready8, cin8, sub8;
  logic [7:0] a8, b8;
  logic       p_in_ready, p_out_valid, p_cout, p_ovf, p_busy;
  logic [7:0] p_s;
  logic       q_in_ready, q_out_valid, q_cout, q_ovf, q_busy;
  logic [7:0] q_s;

  int n_checks = 0;
  int n_errors = 0;

  serial_digit_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf), .busy(busy)
  );

  serial_digit_adder #(.WIDTH(8), .DIGIT(8)) dut_par (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(p_in_ready),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(p_out_valid), .out_ready(out_ready8),
    .s(p_s), .cout(p_cout), .ovf(p_ovf), .busy(p_busy)
  );

  serial_digit_adder #(.WIDTH(8), .DIGIT(1)) dut_bit (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(q_in_ready),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(q_out_valid), .out_ready(out_ready8),
    .s(q_s), .cout(q_cout), .ovf(q_ovf), .busy(q_busy)
  );

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 0; out_ready = 0; a = '0; b = '0; cin = 0; sub = 0;
    in_valid8 = 0; out_ready8 = 0; a8 = '0; b8 = '0; cin8 = 0; sub8 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset busy: got %b want 0", busy); end
    n_checks++;
    if ({s, cout, ovf} !== 18'h0) begin n_errors++; $display("FAIL reset s/cout/ovf: got %h/%b/%b want 0/0/0", s, cout, ovf); end
    n_checks++;
    if ({p_in_ready, q_in_ready, p_out_valid, q_out_valid} !== 4'b1100) begin
      n_errors++; $display("FAIL reset 8-bit handshake: got %b want 1100", {p_in_ready, q_in_ready, p_out_valid, q_out_valid});
    end
  endtask

  // One full transaction with out_ready held high; checks latency, result
  // and the return to IDLE one edge after out_valid rises.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tcin, input logic tsub,
                       input logic [15:0] es, input logic ec, input logic eo, input string nm);
    int lat;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL %s ready before accept: got %b want 1", nm, in_ready); end
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n_checks++;
    if ({in_ready, busy, out_valid} !== 3'b010) begin
      n_errors++; $display("FAIL %s run flags in_ready/busy/out_valid: got %b want 010", nm, {in_ready, busy, out_valid});
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat != 4) begin n_errors++; $display("FAIL %s latency: got %0d want 4", nm, lat); end
    n_checks++;
    if (s !== es) begin n_errors++; $display("FAIL %s s: got %h want %h", nm, s, es); end
    n_checks++;
    if (cout !== ec) begin n_errors++; $display("FAIL %s cout: got %b want %b", nm, cout, ec); end
    n_checks++;
    if (ovf !== eo) begin n_errors++; $display("FAIL %s ovf: got %b want %b", nm, ovf, eo); end
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      n_errors++; $display("FAIL %s return to idle out_valid/in_ready/busy: got %b want 010", nm, {out_valid, in_ready, busy});
    end
  endtask

  task automatic test_add;
    do_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, "add_basic");
  endtask

  task automatic test_sub;
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_neg");
    do_op(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
  endtask

  task automatic test_add_boundaries;
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
  endtask

  task automatic test_backpressure;
    int lat;
    @(negedge clk);
    a = 16'h7FFF; b = 16'h0001; cin = 0; sub = 0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (lat != 4) begin n_errors++; $display("FAIL bp latency: got %0d want 4", lat); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = (k == 2);
      a = 16'h1111; b = 16'h2222;
      @(posedge clk);
      #1 in_valid = 1'b0;
      n_checks++;
      if ({out_valid, in_ready, s, cout, ovf} !== {1'b1, 1'b0, 16'h8000, 1'b0, 1'b1}) begin
        n_errors++;
        $display("FAIL bp hold cycle %0d out_valid/in_ready/s/cout/ovf: got %b/%b/%h/%b/%b want 1/0/8000/0/1",
                 k, out_valid, in_ready, s, cout, ovf);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      n_errors++; $display("FAIL bp release out_valid/in_ready/busy: got %b want 010", {out_valid, in_ready, busy});
    end
    n_checks++;
    if (s !== 16'h8000) begin n_errors++; $display("FAIL bp result kept after release: got %h want 8000", s); end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL bp ignored in_valid started op: busy %b want 0", busy); end
  endtask

  task automatic test_reset_mid_run;
    int seen;
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; cin = 0; sub = 0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);             // accept, counter 0
    #1 in_valid = 1'b0;
    @(posedge clk); #1;         // counter 1
    @(posedge clk); #1;         // counter 2
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_errors++; $display("FAIL midrun flags in_ready/out_valid/busy: got %b want 100", {in_ready, out_valid, busy});
    end
    n_checks++;
    if (s !== 16'h0000) begin n_errors++; $display("FAIL midrun s cleared: got %h want 0000", s); end
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_errors++; $display("FAIL midrun aborted op produced out_valid: got %0d cycles want 0", seen); end
    do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, "post_reset");
  endtask

  task automatic test_width8;
    int lat_p, lat_q;
    logic [9:0] res_p, res_q;
    lat_p = -1; lat_q = -1; res_p = '0; res_q = '0;
    @(negedge clk);
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1; sub8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b1;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      if (p_out_valid === 1'b1 && lat_p < 0) begin lat_p = cyc; res_p = {p_s, p_cout, p_ovf}; end
      if (q_out_valid === 1'b1 && lat_q < 0) begin lat_q = cyc; res_q = {q_s, q_cout, q_ovf}; end
    end
    n_checks++;
    if (lat_p != 1) begin n_errors++; $display("FAIL w8 digit8 latency: got %0d want 1", lat_p); end
    n_checks++;
    if (lat_q != 8) begin n_errors++; $display("FAIL w8 digit1 latency: got %0d want 8", lat_q); end
    n_checks++;
    if (res_p !== {8'h01, 1'b1, 1'b0}) begin
      n_errors++; $display("FAIL w8 digit8 s/cout/ovf: got %h/%b/%b want 01/1/0", res_p[9:2], res_p[1], res_p[0]);
    end
    n_checks++;
    if (res_q !== {8'h01, 1'b1, 1'b0}) begin
      n_errors++; $display("FAIL w8 digit1 s/cout/ovf: got %h/%b/%b want 01/1/0", res_q[9:2], res_q[1], res_q[0]);
    end
    n_checks++;
    if ({p_in_ready, q_in_ready} !== 2'b11) begin
      n_errors++; $display("FAIL w8 back to idle: got %b want 11", {p_in_ready, q_in_ready});
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_add_boundaries();
    test_backpressure();
    test_reset_mid_run();
    test_width8();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_digit_adder.md
# serial_digit_adder

Parametrised multi-cycle adder/subtractor: the successor to the single-bit full-adder cell. Processes WIDTH-bit two's-complement operands DIGIT bits per clock through a ripple chain of full-adder cells, and returns sum, carry-out and signed overflow. Operands enter and results leave over valid/ready handshakes, so the block sits between datapath stages that tolerate multi-cycle latency in exchange for a short carry chain.

## Interface
- WIDTH, 16, operand/result width in bits; WIDTH >= 1
- DIGIT, 4, bits processed per cycle; 1 <= DIGIT <= WIDTH, WIDTH % DIGIT == 0
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand set present
- in_ready  out  1  block can accept operands (high only in IDLE)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in
- sub  in  1  0: a+b+cin; 1: a+~b+cin (cin=1 gives a-b)
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- s  out  WIDTH  sum
- cout  out  1  carry out of MSB
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB
- busy  out  1  high in RUN or DONE

## Operation
- NDIG = WIDTH/DIGIT. States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch a, b^{WIDTH{sub}}, carry=cin, digit counter=0, then go to RUN.
- RUN: each cycle, add the low DIGIT bits of the A/B shift registers with the carry. Shift the sum digit into the top of the internal result register, shift operands right by DIGIT, update carry, increment the counter.
- On the RUN cycle with counter==NDIG-1: load s from the completed result, load cout, load ovf (carry-into-MSB XOR final carry), then go to DONE.
- DONE: out_valid=1. s/cout/ovf are stable. On out_ready, go to IDLE.
- s/cout/ovf hold the last completed result until the next completion. They never show partial sums.
- in_valid is ignored outside IDLE. Inputs a/b/cin/sub are sampled only at the accept edge.
- Reset values: state IDLE, in_ready=1 after reset, out_valid=0, busy=0, s=0, cout=0, ovf=0, counter=0, internal registers 0.
- Reset mid-RUN or in DONE aborts the operation: no out_valid and the result is discarded.
- NDIG=1 (DIGIT=WIDTH): RUN lasts one cycle.

## Timing
- Accept at edge E0. out_valid rises after edge E0+NDIG.
- If out_ready is high in DONE, out_valid lasts exactly one cycle. The return to IDLE happens at edge E0+NDIG+1.
- Minimum accept-to-accept period is NDIG+2 cycles.
- The carry path per cycle is DIGIT full-adder cells. This is the only long combinational path.

## Structure
- Package adder_pkg holds the state encoding constants (IDLE/RUN/DONE) and the counter-width function clog2(NDIG), with a minimum of 1 bit.
- Sub-module digit_adder(DIGIT) is a ripple chain of full-adder cells.
  - Inputs: x, y [DIGIT], ci.
  - Outputs: sum [DIGIT], co, c_msb (carry into the top bit, used for ovf on the last digit).
- Top level contains the FSM, counter, shift registers and output registers.

## Test plan
- WIDTH=16, DIGIT=4: a=0x1234, b=0x0FCD, cin=0, sub=0 -> s=0x2201, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
- sub=1, cin=1: a=0x0005, b=0x0007 -> s=0xFFFE, cout=0, ovf=0. Also a=0x8000, b=0x0001 -> s=0x7FFF, cout=1, ovf=1.
- Add boundaries:
  - a=0x7FFF, b=0x0001 -> s=0x8000, cout=0, ovf=1.
  - a=0xFFFF, b=0x0001 -> s=0x0000, cout=1, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, s, cout and ovf stay constant, in_ready stays 0, and a pulsed in_valid is ignored. Releasing out_ready returns the block to IDLE after one edge.
- Reset during RUN counter=2 -> out_valid never rises, s stays 0, in_ready=1 in the first cycle after rst falls. A following op (0x0001+0x0001) gives s=0x0002.
- WIDTH=8 with DIGIT=8 and with DIGIT=1: a=0xFF, b=0x01, cin=1 -> s=0x01, cout=1, ovf=0. Latency is 1 and 8 cycles respectively.
